// File: rtl/wash_pkg.sv
// Shared motor command codes and drive-state encoding for wash_fsm and wash_motor_drv.
package wash_pkg;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;
  localparam logic [1:0] MOT_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    DEAD = 2'd3
  } drv_state_e;

  function automatic logic is_drive_cmd(input logic [1:0] m);
    return (m == MOT_FWD) || (m == MOT_REV);
  endfunction

endpackage

// File: rtl/wash_motor_drv_pwm_gen.sv
// Free-running PWM counter with registered compare; full duty gives a constant high.
module pwm_gen #(
  parameter int PWM_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic                enable_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic                pwm_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= enable_i & ((duty_i == '1) | (cnt_q < duty_i));
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/wash_motor_drv.sv
// H-bridge driver: soft-start duty ramp, dead-time on every stop/reversal, sticky illegal flag.
module wash_motor_drv
  import wash_pkg::*;
#(
  parameter int DEAD_CYC = 400,
  parameter int PWM_BITS = 6,
  parameter int RAMP_CYC = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] motor,
  output logic       drv_a,
  output logic       drv_b,
  output logic [1:0] dir_q,
  output logic       at_speed,
  output logic       cmd_err
);

  localparam int PWM_MAX = (1 << PWM_BITS) - 1;
  localparam int TMR_MAX = (DEAD_CYC > RAMP_CYC) ? DEAD_CYC : RAMP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  drv_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          dir_lat_q, dir_lat_d;
  logic [1:0]          drv_dir_q;
  logic                at_speed_q;
  logic                cmd_err_q;
  logic                drive_on;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    tmr_d     = tmr_q;
    dir_lat_d = dir_lat_q;
    case (state_q)
      IDLE: begin
        if (is_drive_cmd(motor)) begin
          state_d   = RAMP;
          dir_lat_d = motor;
          duty_d    = '0;
          tmr_d     = '0;
        end
      end
      RAMP: begin
        if (motor != dir_lat_q) begin
          state_d = DEAD;
          duty_d  = '0;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(RAMP_CYC - 1)) begin
          tmr_d  = '0;
          duty_d = duty_q + 1'b1;
          // Enter RUN on the same edge the duty reaches full scale.
          if (duty_q == PWM_BITS'(PWM_MAX - 1)) state_d = RUN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RUN: begin
        if (motor != dir_lat_q) begin
          state_d = DEAD;
          duty_d  = '0;
          tmr_d   = '0;
        end
      end
      DEAD: begin
        if (tmr_q == TMR_W'(DEAD_CYC - 1)) begin
          tmr_d = '0;
          if (is_drive_cmd(motor)) begin
            state_d   = RAMP;
            dir_lat_d = motor;
            duty_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      tmr_q      <= '0;
      dir_lat_q  <= MOT_STOP;
      drv_dir_q  <= MOT_STOP;
      at_speed_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      tmr_q      <= tmr_d;
      dir_lat_q  <= dir_lat_d;
      drv_dir_q  <= ((state_d == RAMP) || (state_d == RUN)) ? dir_lat_d : MOT_STOP;
      at_speed_q <= (state_d == RUN);
      cmd_err_q  <= cmd_err_q | (motor == MOT_ILL);
    end
  end

  assign drive_on = (state_q == RAMP) || (state_q == RUN);

  // One generator per leg; both counters start together at reset and stay in phase.
  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty_i   (duty_q),
    .enable_i (drive_on && (dir_lat_q == MOT_FWD)),
    .pwm_o    (drv_a)
  );

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty_i   (duty_q),
    .enable_i (drive_on && (dir_lat_q == MOT_REV)),
    .pwm_o    (drv_b)
  );

  assign dir_q    = drv_dir_q;
  assign at_speed = at_speed_q;
  assign cmd_err  = cmd_err_q;

  a_legs_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(drv_a && drv_b));

endmodule
